calc_mvd_cost_mul_pipe: RTL and testbench

CALC_MVD_COST_MUL_PIPE -- requirements
Module: calc_mvd_cost_mul_pipe

---
 rtl/calc_mvd_cost_pkg.sv | 23 ++
 rtl/calc_mvd_cost_mul_pipe_if.sv | 26 ++
 rtl/calc_mvd_cost_pipe_ctrl.sv | 46 ++++
 rtl/calc_mvd_cost_mul_pipe.sv | 103 ++++++++++
 tb/tb_calc_mvd_cost_mul_pipe.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_mvd_cost_pkg.sv
// Shared constants, types and helpers for the calc_mvd_cost multiplier pipe.
package calc_mvd_cost_pkg;

    // Deepest pipeline the multiplier supports.
    localparam int MUL_MAX_STAGE = 8;

    // The inflight counter has to hold 0..MUL_MAX_STAGE inclusive.
    localparam int INFLIGHT_W = $clog2(MUL_MAX_STAGE + 1);

    // Operand signedness combination; any signed operand makes the result range signed.
    typedef enum logic [1:0] {
        SM_UNSIGNED,
        SM_MIXED,
        SM_SIGNED
    } sign_mode_e;

    function automatic sign_mode_e sign_mode(input int s0, input int s1);
        if (s0 != 0 && s1 != 0) return SM_SIGNED;
        if (s0 != 0 || s1 != 0) return SM_MIXED;
        return SM_UNSIGNED;
    endfunction

endpackage

// File: rtl/calc_mvd_cost_mul_pipe_if.sv
// Operand/result handshake bundle for calc_mvd_cost_mul_pipe.
// master = producer/consumer side, slave = the multiplier pipe.
interface calc_mvd_cost_mul_pipe_if #(
    parameter int DIN0_WIDTH = 41,
    parameter int DIN1_WIDTH = 64,
    parameter int DOUT_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIN0_WIDTH-1:0] din0;
    logic [DIN1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [DOUT_WIDTH-1:0] dout;
    logic                  out_ovf;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, dout, out_ovf
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, dout, out_ovf
    );
endinterface

// File: rtl/calc_mvd_cost_pipe_ctrl.sv
// Pipeline control: per-stage valid chain, global stall / in_ready, inflight count.
module calc_mvd_cost_pipe_ctrl
    import calc_mvd_cost_pkg::*;
#(
    parameter int NUM_STAGE = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  out_ready,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic                  adv,
    output logic [INFLIGHT_W-1:0] inflight
);
    logic [NUM_STAGE:1] vld_pipe;
    logic               stall;
    logic               acc;
    logic               take;

    // Whole pipe freezes when the output is blocked or ce is low; bubbles do not collapse.
    assign out_valid = vld_pipe[NUM_STAGE];
    assign stall     = (out_valid && !out_ready) || !ce;
    assign adv       = !stall;
    assign in_ready  = adv;
    assign acc       = in_valid && adv;
    assign take      = out_valid && adv;

    // Valid chain: stage 1 takes the acceptance, later stages shift on every advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= acc;
            for (int i = 2; i <= NUM_STAGE; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    // Inflight tracks set valid bits: +1 on acceptance, -1 when the last stage drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) inflight <= '0;
        else          inflight <= inflight + INFLIGHT_W'(acc) - INFLIGHT_W'(take);
    end

endmodule

// File: rtl/calc_mvd_cost_mul_pipe.sv
// Pipelined multiplier with valid/ready flow control and overflow flag.
// Stage 1 registers operands, the full-width product is formed behind it and
// carried through stages 2..NUM_STAGE, then reduced to DOUT_WIDTH at the output.
// Optional: define CALC_MVD_COST_MUL_SAT_EN to clamp out-of-range products
// instead of wrapping (out_ovf is reported either way).
module calc_mvd_cost_mul_pipe
    import calc_mvd_cost_pkg::*;
#(
    parameter int DIN0_WIDTH  = 41,
    parameter int DIN1_WIDTH  = 64,
    parameter int DOUT_WIDTH  = 64,
    parameter int NUM_STAGE   = 5,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            ce,
    calc_mvd_cost_mul_pipe_if.slave         bus,
    output logic [INFLIGHT_W-1:0]           inflight
);
    localparam int         PW   = DIN0_WIDTH + DIN1_WIDTH + 1;
    localparam int         EXT0 = PW - DIN0_WIDTH;
    localparam int         EXT1 = PW - DIN1_WIDTH;
    localparam sign_mode_e MODE = sign_mode(DIN0_SIGNED, DIN1_SIGNED);
    localparam bit         SGN  = (MODE != SM_UNSIGNED);

    logic                  adv;
    logic [DIN0_WIDTH-1:0] a_q;
    logic [DIN1_WIDTH-1:0] b_q;
    logic [PW-1:0]         ae;
    logic [PW-1:0]         be;
    logic [PW-1:0]         prod_s1;
    logic [PW-1:0]         prod_fin;
    logic [DOUT_WIDTH-1:0] dout_c;
    logic                  ovf_c;

    calc_mvd_cost_pipe_ctrl #(.NUM_STAGE(NUM_STAGE)) u_ctrl (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .in_valid  (bus.in_valid),
        .out_ready (bus.out_ready),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .adv       (adv),
        .inflight  (inflight)
    );

    // Stage 1: operand capture; data moves with the valid chain, bubbles carry don't-care data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else if (adv) begin
            a_q <= bus.din0;
            b_q <= bus.din1;
        end
    end

    // Extending both operands to PW makes the modulo-2^PW product exact for every sign mix.
    assign ae      = (DIN0_SIGNED != 0) ? {{EXT0{a_q[DIN0_WIDTH-1]}}, a_q} : {{EXT0{1'b0}}, a_q};
    assign be      = (DIN1_SIGNED != 0) ? {{EXT1{b_q[DIN1_WIDTH-1]}}, b_q} : {{EXT1{1'b0}}, b_q};
    assign prod_s1 = ae * be;

    generate
        if (NUM_STAGE == 1) begin : g_one
            assign prod_fin = prod_s1;
        end else begin : g_pp
            logic [NUM_STAGE:2][PW-1:0] pp;

            // Stages 2..NUM_STAGE: full-width product shift chain.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    pp <= '0;
                end else if (adv) begin
                    pp[2] <= prod_s1;
                    for (int i = 3; i <= NUM_STAGE; i++) pp[i] <= pp[i-1];
                end
            end

            assign prod_fin = pp[NUM_STAGE];
        end
    endgenerate

    // Final-stage reduction: range check, then wrap or clamp to DOUT_WIDTH.
    always_comb begin
        dout_c = prod_fin[DOUT_WIDTH-1:0];
        if (SGN) ovf_c = !((&prod_fin[PW-1:DOUT_WIDTH-1]) || !(|prod_fin[PW-1:DOUT_WIDTH-1]));
        else     ovf_c = |prod_fin[PW-1:DOUT_WIDTH];
`ifdef CALC_MVD_COST_MUL_SAT_EN
        if (ovf_c) begin
            if (!SGN)               dout_c = '1;
            else if (prod_fin[PW-1]) dout_c = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
            else                    dout_c = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end
`endif
    end

    assign bus.dout    = dout_c;
    assign bus.out_ovf = ovf_c;

endmodule

// File: tb/tb_calc_mvd_cost_mul_pipe.sv
// Self-checking bench for calc_mvd_cost_mul_pipe: scoreboard on the default
// configuration plus a 16-bit signed instance for the overflow corner cases.
module tb_calc_mvd_cost_mul_pipe;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b1;
    logic [3:0] infl_a;
    logic [3:0] infl_b;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    calc_mvd_cost_mul_pipe_if #(.DIN0_WIDTH(41), .DIN1_WIDTH(64), .DOUT_WIDTH(64)) bus_a ();
    calc_mvd_cost_mul_pipe_if #(.DIN0_WIDTH(16), .DIN1_WIDTH(16), .DOUT_WIDTH(16)) bus_b ();

    calc_mvd_cost_mul_pipe u_dut_a (
        .clk(clk), .reset_n(reset_n), .ce(ce), .bus(bus_a.slave), .inflight(infl_a)
    );

    calc_mvd_cost_mul_pipe #(
        .DIN0_WIDTH(16), .DIN1_WIDTH(16), .DOUT_WIDTH(16),
        .NUM_STAGE(5), .DIN0_SIGNED(1), .DIN1_SIGNED(1)
    ) u_dut_b (
        .clk(clk), .reset_n(reset_n), .ce(ce), .bus(bus_b.slave), .inflight(infl_b)
    );

    typedef struct {
        logic [63:0] d;
        logic        o;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];

    localparam logic signed [127:0] SMAX = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] SMIN = -128'sh8000_0000_0000_0000;

    // Reference: A unsigned 41b, B signed 64b, signed 64b result range.
    function automatic exp_t model(input logic [40:0] a, input logic [63:0] b);
        exp_t r;
        logic signed [127:0] p;
        p   = $signed({87'd0, a}) * $signed({{64{b[63]}}, b});
        r.o = (p > SMAX) || (p < SMIN);
        r.d = p[63:0];
`ifdef CALC_MVD_COST_MUL_SAT_EN
        if (r.o) r.d = (p < 0) ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: a transfer happens at the next edge when valid, ready and ce are all high.
    always begin
        @(negedge clk);
        #2;
        if (reset_n && ce && bus_a.out_valid && bus_a.out_ready) begin
            if (sb.size() == 0) begin
                chk("stale_result", {63'd0, bus_a.out_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_dout", bus_a.dout, e.d);
                chk("sb_ovf", {63'd0, bus_a.out_ovf}, {63'd0, e.o});
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Offer one pair at a negedge until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic [40:0] a, input logic [63:0] b);
        logic acc;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            bus_a.in_valid = 1'b1;
            bus_a.din0     = a;
            bus_a.din1     = b;
            #1;
            acc = bus_a.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sb.push_back(model(a, b));
                bus_a.in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 64'd0, 64'd1);
        bus_a.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (sb.size() == 0 && infl_a == 4'd0) break;
        end
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        chk("drain_inflight", {60'd0, infl_a}, 64'd0);
    endtask

    // One isolated transaction on the 16-bit signed instance.
    task automatic run_b(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_d, input logic exp_o);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        bus_b.in_valid = 1'b1;
        bus_b.din0     = a;
        bus_b.din1     = b;
        @(posedge clk);
        #1;
        bus_b.in_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #2;
            if (bus_b.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_valid"}, {63'd0, seen}, 64'd1);
        chk({tag, "_dout"}, {48'd0, bus_b.dout}, {48'd0, exp_d});
        chk({tag, "_ovf"}, {63'd0, bus_b.out_ovf}, {63'd0, exp_o});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        bus_a.in_valid = 1'b0; bus_a.din0 = '0; bus_a.din1 = '0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.din0 = '0; bus_b.din1 = '0; bus_b.out_ready = 1'b1;

        // Reset state
        #3;
        chk("rst_out_valid", {63'd0, bus_a.out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, bus_a.in_ready}, 64'd1);
        chk("rst_inflight", {60'd0, infl_a}, 64'd0);
        chk("rst_dout", bus_a.dout, 64'd0);
        chk("rst_ovf", {63'd0, bus_a.out_ovf}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Scenario 1: latency. The acceptance edge loads stage 1, stage 5 is loaded four edges later.
        send(41'd3, -64'sd5);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #3;
            chk($sformatf("s1_valid_k%0d", k), {63'd0, bus_a.out_valid}, (k == 5) ? 64'd1 : 64'd0);
        end
        chk("s1_dout", bus_a.dout, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("s1_ovf", {63'd0, bus_a.out_ovf}, 64'd0);
        drain();

        // Scenario 2: back-to-back, one result per cycle in order.
        pop_cyc.delete();
        for (int i = 0; i < 10; i++) send(41'(i), 64'(i + 1));
        drain();
        chk("s2_count", 64'(pop_cyc.size()), 64'd10);
        if (pop_cyc.size() == 10) chk("s2_span", 64'(pop_cyc[9] - pop_cyc[0]), 64'd9);

        // Scenario 3: backpressure, with boundary operands first then random ones.
        fork
            begin
                send(41'h100_0000_0000, 64'h0000_0100_0000_0000);
                send(41'd2, 64'h8000_0000_0000_0000);
                send(41'd1, 64'h8000_0000_0000_0000);
                for (int i = 0; i < 5; i++) send(41'({$urandom, $urandom}), {$urandom, $urandom});
            end
            begin
                logic seen;
                seen = 1'b0;
                for (int t = 0; t < 50; t++) begin
                    @(negedge clk);
                    if (bus_a.out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                chk("s3_first_valid", {63'd0, seen}, 64'd1);
                bus_a.out_ready = 1'b0;
                for (int i = 0; i < 7; i++) begin
                    if (i > 0) @(negedge clk);
                    #3;
                    if (i == 0) held = bus_a.dout;
                    chk("s3_in_ready", {63'd0, bus_a.in_ready}, 64'd0);
                    chk("s3_out_valid", {63'd0, bus_a.out_valid}, 64'd1);
                    chk("s3_dout_hold", bus_a.dout, held);
                    chk("s3_inflight", {60'd0, infl_a}, 64'd5);
                end
                @(negedge clk);
                bus_a.out_ready = 1'b1;
            end
        join
        drain();

        // Scenario 4: 16-bit signed instance, wrap/clamp and exact-boundary products.
`ifdef CALC_MVD_COST_MUL_SAT_EN
        run_b("s4_pos_ovf", 16'd300, 16'd300, 16'h7FFF, 1'b1);
        run_b("s4_neg_ovf", -16'sd300, 16'd300, 16'h8000, 1'b1);
        run_b("s4_plus_32768", 16'd256, 16'd128, 16'h7FFF, 1'b1);
`else
        run_b("s4_pos_ovf", 16'd300, 16'd300, 16'h5F90, 1'b1);
        run_b("s4_neg_ovf", -16'sd300, 16'd300, 16'hA070, 1'b1);
        run_b("s4_plus_32768", 16'd256, 16'd128, 16'h8000, 1'b1);
`endif
        run_b("s4_minus_32768", -16'sd256, 16'd128, 16'h8000, 1'b0);
        run_b("s4_fit_max", 16'd181, 16'd181, 16'h7FF9, 1'b0);

        // Scenario 5: asynchronous reset with three results parked in the back stages.
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(41'(100 + i), 64'd7);
        repeat (3) @(negedge clk);
        #3;
        chk("s5_pre_valid", {63'd0, bus_a.out_valid}, 64'd1);
        chk("s5_pre_inflight", {60'd0, infl_a}, 64'd3);
        reset_n = 1'b0;
        #1;
        chk("s5_async_valid", {63'd0, bus_a.out_valid}, 64'd0);
        chk("s5_async_inflight", {60'd0, infl_a}, 64'd0);
        chk("s5_async_dout", bus_a.dout, 64'd0);
        sb.delete();
        bus_a.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus_a.in_valid = 1'b1;
        bus_a.din0 = 41'd9;
        bus_a.din1 = 64'd11;
        #1;
        chk("s5_first_in_ready", {63'd0, bus_a.in_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
        sb.push_back(model(41'd9, 64'd11));
        chk("s5_first_accept", {60'd0, infl_a}, 64'd1);
        drain();

        // Scenario 6: ce low for four cycles with a full pipe.
        for (int i = 0; i < 5; i++) send(41'(20 + i), -64'sd3);
        held = bus_a.dout;
        @(negedge clk);
        ce = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.din0 = 41'd55;
        bus_a.din1 = 64'd66;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            #3;
            chk("s6_in_ready", {63'd0, bus_a.in_ready}, 64'd0);
            chk("s6_out_valid", {63'd0, bus_a.out_valid}, 64'd1);
            chk("s6_inflight", {60'd0, infl_a}, 64'd5);
            chk("s6_dout_hold", bus_a.dout, held);
        end
        @(negedge clk);
        ce = 1'b1;
        bus_a.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) send(41'(40 + i), 64'(i * 1000));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
